markov_predictor: RTL and testbench

//  Parametrised N-th order Markov opponent for rock-paper-scissors. Keeps a

---
 rtl/markov_predictor.sv | 168 ++++++++++++++++
 tb/tb_markov_predictor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/markov_predictor.sv
// N-th order Markov rock-paper-scissors opponent: counts the user's next move per history context and plays the move beating the argmax.
// Optional score counters (wins/losses/ties) are built only when MARKOV_STATS_EN is defined.
module markov_predictor #(
    parameter int ORDER  = 1,
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              user_valid,
    input  logic [1:0]        user,
    output logic              ready,
    output logic [1:0]        choice,
    output logic [1:0]        predicted,
    output logic              err
`ifdef MARKOV_STATS_EN
    ,
    output logic [STAT_W-1:0] wins,
    output logic [STAT_W-1:0] losses,
    output logic [STAT_W-1:0] ties
`endif
);

    // state   | meaning
    // S_INIT    | clearing one table row per cycle after reset
    // S_IDLE    | ready, waiting for a legal user move
    // S_UPDATE  | train counter for old context, shift move into context
    // S_PREDICT | read row of new context, register prediction and choice

    localparam int ROWS   = (ORDER == 1) ? 3 : (ORDER == 2) ? 9 : 27;
    localparam int IDX_W  = $clog2(ROWS);
    localparam int T_W    = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (ORDER < 1 || ORDER > 3 || CNT_W < 1 || STAT_W < 1) begin : g_bad_param
        $error("markov_predictor: illegal parameter value");
    end

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE, S_PREDICT} state_t;

    state_t           state;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] ctx;
    logic [IDX_W-1:0] ctx_next;
    logic [1:0]       hist_cnt;
    logic [1:0]       rnd;
    logic [1:0]       mv;
    logic [CNT_W-1:0] tab [ROWS][3];
    logic [CNT_W-1:0] row [3];
    logic [CNT_W-1:0] upd [3];
    logic [CNT_W-1:0] mx;
    logic [2:0]       eq;
    logic [1:0]       argmax;
    logic [1:0]       pick;
    logic [T_W-1:0]   ctx_t;

    function automatic logic [1:0] beat(input logic [1:0] m);
        case (m)
            2'b00:   beat = 2'b10;
            2'b01:   beat = 2'b00;
            default: beat = 2'b01;
        endcase
    endfunction

    // Saturating counter: halve the whole row before incrementing a full counter.
    always_comb begin
        for (int k = 0; k < 3; k++) row[k] = tab[ctx][k];
        upd = row;
        if (row[mv] == CNT_MAX) begin
            for (int k = 0; k < 3; k++) upd[k] = row[k] >> 1;
        end
        upd[mv] = upd[mv] + 1'b1;
    end

    // ctx*3 + mv is below 3*ROWS, so at most two subtractions reduce it mod ROWS.
    always_comb begin
        ctx_t = T_W'(ctx) * T_W'(3) + T_W'(mv);
        if (ctx_t >= T_W'(2 * ROWS))
            ctx_t = ctx_t - T_W'(2 * ROWS);
        else if (ctx_t >= T_W'(ROWS))
            ctx_t = ctx_t - T_W'(ROWS);
        ctx_next = ctx_t[IDX_W-1:0];
    end

    always_comb begin
        mx = row[0];
        if (row[1] > mx) mx = row[1];
        if (row[2] > mx) mx = row[2];
        eq = {row[2] == mx, row[1] == mx, row[0] == mx};
        case (eq)
            3'b111:  argmax = rnd;
            3'b011:  argmax = rnd[0] ? 2'd1 : 2'd0;
            3'b101:  argmax = rnd[0] ? 2'd2 : 2'd0;
            3'b110:  argmax = rnd[0] ? 2'd2 : 2'd1;
            3'b001:  argmax = 2'd0;
            3'b010:  argmax = 2'd1;
            default: argmax = 2'd2;
        endcase
        pick = (hist_cnt < 2'(ORDER)) ? rnd : argmax;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_INIT;
            row_idx   <= '0;
            ctx       <= '0;
            hist_cnt  <= '0;
            rnd       <= '0;
            mv        <= '0;
            ready     <= 1'b0;
            choice    <= 2'b00;
            predicted <= 2'b00;
            err       <= 1'b0;
`ifdef MARKOV_STATS_EN
            wins      <= '0;
            losses    <= '0;
            ties      <= '0;
`endif
        end else begin
            rnd <= (rnd == 2'd2) ? 2'd0 : rnd + 2'd1;
            err <= 1'b0;
            case (state)
                S_INIT: begin
                    for (int k = 0; k < 3; k++) tab[row_idx][k] <= '0;
                    row_idx <= row_idx + 1'b1;
                    if (row_idx == IDX_W'(ROWS - 1)) state <= S_PREDICT;
                end
                S_IDLE: begin
                    if (user_valid) begin
                        if (user == 2'b11) begin
                            err <= 1'b1;
                        end else begin
                            mv    <= user;
                            ready <= 1'b0;
                            state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (hist_cnt == 2'(ORDER)) begin
                        for (int k = 0; k < 3; k++) tab[ctx][k] <= upd[k];
                    end else begin
                        hist_cnt <= hist_cnt + 2'd1;
                    end
                    ctx <= ctx_next;
`ifdef MARKOV_STATS_EN
                    if (mv == choice) begin
                        if (ties != '1) ties <= ties + 1'b1;
                    end else if (beat(mv) == choice) begin
                        if (wins != '1) wins <= wins + 1'b1;
                    end else begin
                        if (losses != '1) losses <= losses + 1'b1;
                    end
`endif
                    state <= S_PREDICT;
                end
                S_PREDICT: begin
                    predicted <= pick;
                    choice    <= beat(pick);
                    ready     <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_markov_predictor.sv
// Bench for markov_predictor: an ORDER=1/CNT_W=8 instance and an ORDER=2/CNT_W=2 instance
// checked against a behavioural model through an expected-result queue.
`timescale 1ns/1ps
module tb_markov_predictor;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] rst = 2'b00;
    logic [1:0] uv  = 2'b00;
    logic [3:0] us  = 4'b0000;
    logic [1:0] rdy;
    logic [3:0] ch;
    logic [3:0] pr;
    logic [1:0] er;
`ifdef MARKOV_STATS_EN
    logic [31:0] wn;
    logic [31:0] ls;
    logic [31:0] tz;
`endif

    markov_predictor #(.ORDER(1), .CNT_W(8), .STAT_W(16)) u_o1 (
        .clock(clock), .reset(rst[0]), .user_valid(uv[0]), .user(us[1:0]),
        .ready(rdy[0]), .choice(ch[1:0]), .predicted(pr[1:0]), .err(er[0])
`ifdef MARKOV_STATS_EN
        , .wins(wn[15:0]), .losses(ls[15:0]), .ties(tz[15:0])
`endif
    );

    markov_predictor #(.ORDER(2), .CNT_W(2), .STAT_W(16)) u_o2 (
        .clock(clock), .reset(rst[1]), .user_valid(uv[1]), .user(us[3:2]),
        .ready(rdy[1]), .choice(ch[3:2]), .predicted(pr[3:2]), .err(er[1])
`ifdef MARKOV_STATS_EN
        , .wins(wn[31:16]), .losses(ls[31:16]), .ties(tz[31:16])
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [1:0] pred; logic [1:0] ch; } exp_t;
    exp_t sb[$];

    // reference state, index 0 = ORDER 1 instance, 1 = ORDER 2 instance
    int ord [2]    = '{1, 2};
    int rows_n [2] = '{3, 9};
    int cmax [2]   = '{255, 3};
    int m_tab [2][27][3];
    int m_hist [2];
    int m_ctx [2];
    int m_rnd [2]  = '{0, 0};
    int m_w [2];
    int m_l [2];
    int m_t [2];
    logic [1:0] m_choice [2];
    logic [1:0] m_pred [2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) m_rnd[i] <= 0;
            else         m_rnd[i] <= (m_rnd[i] == 2) ? 0 : m_rnd[i] + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] beat_f(input logic [1:0] m);
        case (m)
            2'b00:   return 2'b10;
            2'b01:   return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    function automatic void model_reset(input int d);
        for (int r = 0; r < 27; r++)
            for (int k = 0; k < 3; k++) m_tab[d][r][k] = 0;
        m_hist[d]   = 0;
        m_ctx[d]    = 0;
        m_w[d]      = 0;
        m_l[d]      = 0;
        m_t[d]      = 0;
        m_pred[d]   = 2'(rows_n[d] % 3);
        m_choice[d] = beat_f(m_pred[d]);
    endfunction

    function automatic logic [1:0] model_move(input int d, input int u, input int r);
        int c, mx, n, lo, hi;
        logic [1:0] p;
        if (2'(u) == m_choice[d])              m_t[d]++;
        else if (beat_f(2'(u)) == m_choice[d]) m_w[d]++;
        else                                   m_l[d]++;
        if (m_hist[d] == ord[d]) begin
            c = m_ctx[d];
            if (m_tab[d][c][u] == cmax[d])
                for (int k = 0; k < 3; k++) m_tab[d][c][k] = m_tab[d][c][k] / 2;
            m_tab[d][c][u]++;
        end else begin
            m_hist[d]++;
        end
        m_ctx[d] = (m_ctx[d] * 3 + u) % rows_n[d];
        if (m_hist[d] < ord[d]) begin
            p = 2'(r);
        end else begin
            c = m_ctx[d];
            mx = m_tab[d][c][0];
            for (int k = 1; k < 3; k++) if (m_tab[d][c][k] > mx) mx = m_tab[d][c][k];
            n = 0; lo = -1; hi = -1;
            for (int k = 0; k < 3; k++)
                if (m_tab[d][c][k] == mx) begin
                    n++;
                    if (lo < 0) lo = k;
                    hi = k;
                end
            if (n == 3)      p = 2'(r);
            else if (n == 1) p = 2'(lo);
            else             p = (r % 2 == 0) ? 2'(lo) : 2'(hi);
        end
        m_pred[d]   = p;
        m_choice[d] = beat_f(p);
        return p;
    endfunction

    // One round: push the expectation at drive time, return what the DUT shows after edge N+2.
    task automatic do_move(input int d, input int u, input bit pulse,
                           output logic [1:0] o_pred, output logic [1:0] o_ch, output bit lat_ok);
        logic [1:0] p;
        @(negedge clock);
        p = model_move(d, u, (m_rnd[d] + 2) % 3);
        sb.push_back('{pred: p, ch: beat_f(p)});
        uv[d] = 1'b1;
        us[2*d +: 2] = 2'(u);
        @(posedge clock); #1;
        uv[d] = 1'b0;
        lat_ok = (rdy[d] === 1'b0);
        @(posedge clock); #1;
        if (pulse) begin
            uv[d] = 1'b1;
            us[2*d +: 2] = 2'b01;
        end
        @(posedge clock); #1;
        uv[d] = 1'b0;
        lat_ok = lat_ok && (rdy[d] === 1'b1);
        o_pred = pr[2*d +: 2];
        o_ch   = ch[2*d +: 2];
    endtask

    task automatic hold_reset(input int d);
        @(negedge clock);
        rst[d] = 1'b0;
        uv[d]  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic release_wait(input int d, output int cyc);
        @(negedge clock);
        rst[d] = 1'b1;
        model_reset(d);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (rdy[d] !== 1'b1 && cyc < 100);
    endtask

    task automatic test_reset();
        int cyc;
        for (int d = 0; d < 2; d++) begin
            hold_reset(d);
            vectors++; if (rdy[d] !== 1'b0) begin miscompares++; $display("FAIL reset_ready[%0d]: got %0d want 0", d, rdy[d]); end
            vectors++; if (ch[2*d +: 2] !== 2'b00) begin miscompares++; $display("FAIL reset_choice[%0d]: got %0d want 0", d, ch[2*d +: 2]); end
            vectors++; if (pr[2*d +: 2] !== 2'b00) begin miscompares++; $display("FAIL reset_pred[%0d]: got %0d want 0", d, pr[2*d +: 2]); end
            vectors++; if (er[d] !== 1'b0) begin miscompares++; $display("FAIL reset_err[%0d]: got %0d want 0", d, er[d]); end
            release_wait(d, cyc);
            vectors++; if (cyc != rows_n[d] + 1) begin miscompares++; $display("FAIL init_cycles[%0d]: got %0d want %0d", d, cyc, rows_n[d] + 1); end
            vectors++; if (pr[2*d +: 2] !== m_pred[d]) begin miscompares++; $display("FAIL init_pred[%0d]: got %0d want %0d", d, pr[2*d +: 2], m_pred[d]); end
            vectors++; if (ch[2*d +: 2] !== m_choice[d]) begin miscompares++; $display("FAIL init_choice[%0d]: got %0d want %0d", d, ch[2*d +: 2], m_choice[d]); end
        end
    endtask

    task automatic test_order1();
        int seq [10] = '{0, 0, 0, 0, 1, 2, 1, 1, 0, 2};
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            do_move(0, seq[i], 1'b0, op, oc, lat);
            e = sb.pop_front();
            vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL o1_pred[%0d]: got %0d want %0d", i, op, e.pred); end
            vectors++; if (oc !== e.ch) begin miscompares++; $display("FAIL o1_choice[%0d]: got %0d want %0d", i, oc, e.ch); end
            vectors++; if (!lat) begin miscompares++; $display("FAIL o1_latency[%0d]: got 0 want 1", i); end
        end
    endtask

    task automatic test_order2_halving();
        int seq [25] = '{0, 1, 2, 0, 1, 2, 0, 1, 2,
                         0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 2, 0, 0, 0};
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            do_move(1, seq[i], 1'b0, op, oc, lat);
            e = sb.pop_front();
            vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL o2_pred[%0d]: got %0d want %0d", i, op, e.pred); end
            vectors++; if (oc !== e.ch) begin miscompares++; $display("FAIL o2_choice[%0d]: got %0d want %0d", i, oc, e.ch); end
            vectors++; if (!lat) begin miscompares++; $display("FAIL o2_latency[%0d]: got 0 want 1", i); end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        @(negedge clock);
        uv[0] = 1'b1;
        us[1:0] = 2'b11;
        @(posedge clock); #1;
        uv[0] = 1'b0;
        vectors++; if (er[0] !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %0d want 1", er[0]); end
        vectors++; if (rdy[0] !== 1'b1) begin miscompares++; $display("FAIL err_ready: got %0d want 1", rdy[0]); end
        vectors++; if (ch[1:0] !== m_choice[0]) begin miscompares++; $display("FAIL err_choice: got %0d want %0d", ch[1:0], m_choice[0]); end
        vectors++; if (pr[1:0] !== m_pred[0]) begin miscompares++; $display("FAIL err_pred: got %0d want %0d", pr[1:0], m_pred[0]); end
        @(posedge clock); #1;
        vectors++; if (er[0] !== 1'b0) begin miscompares++; $display("FAIL err_width: got %0d want 0", er[0]); end
        for (int i = 0; i < 3; i++) begin
            do_move(0, i, 1'b0, op, oc, lat);
            e = sb.pop_front();
            vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL err_after_pred[%0d]: got %0d want %0d", i, op, e.pred); end
        end
    endtask

    task automatic test_ignore_busy();
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        do_move(0, 2, 1'b1, op, oc, lat);
        e = sb.pop_front();
        vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL busy_pred: got %0d want %0d", op, e.pred); end
        vectors++; if (!lat) begin miscompares++; $display("FAIL busy_latency: got 0 want 1"); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            vectors++; if (rdy[0] !== 1'b1) begin miscompares++; $display("FAIL busy_ready_hold[%0d]: got %0d want 1", i, rdy[0]); end
            vectors++; if (ch[1:0] !== e.ch) begin miscompares++; $display("FAIL busy_choice_hold[%0d]: got %0d want %0d", i, ch[1:0], e.ch); end
        end
        do_move(0, 0, 1'b0, op, oc, lat);
        e = sb.pop_front();
        vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL busy_next_pred: got %0d want %0d", op, e.pred); end
    endtask

    task automatic test_abort();
        int cyc;
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        @(negedge clock);
        uv[0] = 1'b1;
        us[1:0] = 2'b01;
        @(posedge clock); #1;
        uv[0] = 1'b0;
        @(negedge clock);
        rst[0] = 1'b0;
        @(posedge clock); #1;
        vectors++; if (rdy[0] !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %0d want 0", rdy[0]); end
        vectors++; if (ch[1:0] !== 2'b00) begin miscompares++; $display("FAIL abort_choice: got %0d want 0", ch[1:0]); end
        vectors++; if (pr[1:0] !== 2'b00) begin miscompares++; $display("FAIL abort_pred: got %0d want 0", pr[1:0]); end
        vectors++; if (er[0] !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %0d want 0", er[0]); end
        release_wait(0, cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL abort_init_cycles: got %0d want 4", cyc); end
        for (int i = 0; i < 3; i++) begin
            do_move(0, 0, 1'b0, op, oc, lat);
            e = sb.pop_front();
            vectors++; if (op !== e.pred) begin miscompares++; $display("FAIL abort_after_pred[%0d]: got %0d want %0d", i, op, e.pred); end
            vectors++; if (oc !== e.ch) begin miscompares++; $display("FAIL abort_after_choice[%0d]: got %0d want %0d", i, oc, e.ch); end
        end
    endtask

`ifdef MARKOV_STATS_EN
    task automatic test_stats();
        int mvs [3] = '{0, 2, 1};
        int cyc;
        logic [1:0] op, oc;
        bit lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            hold_reset(0);
            release_wait(0, cyc);
            do_move(0, mvs[i], 1'b0, op, oc, lat);
            e = sb.pop_front();
            vectors++; if (wn[15:0] !== 16'(m_w[0])) begin miscompares++; $display("FAIL stats_wins[%0d]: got %0d want %0d", i, wn[15:0], m_w[0]); end
            vectors++; if (ls[15:0] !== 16'(m_l[0])) begin miscompares++; $display("FAIL stats_losses[%0d]: got %0d want %0d", i, ls[15:0], m_l[0]); end
            vectors++; if (tz[15:0] !== 16'(m_t[0])) begin miscompares++; $display("FAIL stats_ties[%0d]: got %0d want %0d", i, tz[15:0], m_t[0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_order1();
        test_order2_halving();
        test_illegal();
        test_ignore_busy();
        test_abort();
`ifdef MARKOV_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
